vid_scanout: RTL and testbench
==============================

# vid_scanout

Frame scan-out engine on the video read port of the framebuffer SPRAM pair. On a frame-start request it walks the framebuffer linearly and issues one 32-bit word read per fetch slot, tolerating the port's fixed one-cycle read latency. Read words go into a small word FIFO, are unpacked into 8-bit palette indices (LSB byte first), and are presented to the downstream palette/LCD stage over a valid/ready stream.

## Interface
- `N_WORDS`, 16000: words per frame (320×200 bytes / 4); range 1..16384.
- `BASE_ADDR`, 0: word address of the first framebuffer word.
- `FIFO_DEPTH`, 4: word FIFO depth, power of two, ≥2.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse requesting a full frame scan.
- `busy` out 1: a scan is in progress; high from the cycle after an accepted `frame_start` until the last pixel handshake.
- `v_addr_0` out 14: framebuffer word address. Driven from flops.
- `v_re_0` out 1: framebuffer read strobe. Driven from a flop.
- `v_data_1` in 32: read data, valid the cycle after `v_re_0`.
- `pix_data` out 8: palette index.
- `pix_valid` out 1: `pix_data` is valid.
- `pix_ready` in 1: downstream accepts the pixel.
- `pix_first` out 1: qualifies the first pixel of the frame.
- `pix_last` out 1: qualifies the last pixel of the frame.

## Operation
- **States:** IDLE, FETCH, DRAIN.
- **IDLE:**
  - `frame_start` loads address ← `BASE_ADDR` and the word counter ← 0, then moves to FETCH.
  - `frame_start` in FETCH or DRAIN is ignored.
- **FETCH:**
  - Issue a read when (FIFO occupancy + in-flight reads) < `FIFO_DEPTH`, i.e. credit-based, so the FIFO never overflows.
  - Each issue increments the address (14-bit wrap) and the word counter.
  - After issuing word `N_WORDS`-1, move to DRAIN.
- **DRAIN:**
  - No reads are issued.
  - Return to IDLE on the handshake (`pix_valid & pix_ready`) of the pixel flagged `pix_last`.
- **Capture:** `v_data_1` is written into the FIFO unconditionally in the cycle after each `v_re_0`. The FIFO therefore has no back-pressure path to the RAM.
- **Unpacker:**
  - Holds one word and a 2-bit byte index. Output bytes in order [7:0], [15:8], [23:16], [31:24].
  - Pops the FIFO when empty-handed or when byte 3 is handshaked. A pop may coincide with the byte-3 handshake, so there are no bubbles.
- **Markers:**
  - `pix_first` is high on byte 0 of word 0.
  - `pix_last` is high on byte 3 of word `N_WORDS`-1.
- **Stream rules:**
  - `pix_valid` never drops without a handshake.
  - `pix_data`, `pix_first` and `pix_last` are stable while `pix_valid & ~pix_ready`.

## Timing
- **Reset values:** all outputs 0 (`v_addr_0` = 0, `v_re_0` = 0, `busy` = 0, `pix_*` = 0); state IDLE; FIFO empty.
- **Latency:**
  - `frame_start` in cycle T: `busy` = 1 and the first `v_re_0` = 1 in T+1.
  - The word enters the FIFO at T+2.
  - `pix_valid` = 1 at T+3.
- **Throughput:**
  - With `pix_ready` held high: 1 pixel per cycle, which needs 1 read per 4 cycles.
  - Reads are issued back-to-back only while credits allow.
- **Reset mid-scan:** asynchronous return to IDLE; in-flight read data is discarded; the next frame starts clean.
- **`N_WORDS` = 1:** `pix_first` and `pix_last` fall on different bytes of the single word. FETCH lasts exactly one issue cycle.
- **Simultaneous events:**
  - The FIFO must support push and pop in the same cycle.
  - Push into an empty FIFO plus a pop request in the same cycle: data is available next cycle, with no flow-through.

## Configuration
- `VID_SCANOUT_THROTTLE_EN`:
  - **Defined:** `v_re_0` is never high in two consecutive cycles. At least one idle cycle follows every read, guaranteeing the aux (CPU) port a slot at least every other cycle.
  - **Undefined:** reads are limited only by FIFO credits.
  - Pixel order and stream behaviour are identical in both cases; only the cycle timing of reads differs.

## Structure
- **Shared video package/header:**
  - Pixel width (8), word width (32), framebuffer address width (14).
  - Default frame words (16000).
  - Scan-out state encodings.
- **Sub-module:** `vid_word_fifo`, a synchronous FIFO.
  - Parameterised width/depth.
  - Push/pop with registered output; exposes a level count for credit accounting.
  - Async active-high reset.

## Test plan
- **Reset state:** assert `rst` for 3 cycles, release → all outputs 0, `busy` = 0. With no `frame_start`, `v_re_0` stays 0 for 100 cycles.
- **Full-rate frame:** `N_WORDS` = 16, RAM model word k = {4k+3, 4k+2, 4k+1, 4k}, `pix_ready` = 1 → 64 pixels valued 0..63 in order. `pix_first` only on 0, `pix_last` only on 63. `busy` falls after pixel 63. First `pix_valid` exactly 3 cycles after `frame_start`.
- **Random back-pressure:** `pix_ready` random at 30 % → identical pixel sequence, no FIFO overflow, and no more than `FIFO_DEPTH` words outstanding (FIFO + in flight) at any time.
- **Throttle:** with `VID_SCANOUT_THROTTLE_EN` defined and `pix_ready` = 1 → `v_re_0` never high in consecutive cycles; pixel sequence unchanged.
- **Ignored restart:** `frame_start` pulsed mid-frame → ignored; exactly `4·N_WORDS` pixels emitted. A second `frame_start` after `busy` falls → new frame starting at `BASE_ADDR`.
- **Reset mid-scan:** assert `rst` after 20 pixels → outputs 0 immediately. A new frame then emits pixels from 0 with `pix_first` set.

Source files
------------

// File: rtl/vid_scanout_pkg.sv
// vid_scanout_pkg: shared definitions for the video scan-out path.
//   - pixel, word and framebuffer address widths
//   - default frame size in words (320x200 bytes / 4)
//   - scan-out FSM state encodings
//   - word_byte(): selects one palette index out of a framebuffer word
package vid_scanout_pkg;

  localparam int PIX_W           = 8;
  localparam int WORD_W          = 32;
  localparam int ADDR_W          = 14;
  localparam int DEFAULT_N_WORDS = 16000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Byte 0 is bits [7:0]; pixels leave a word LSB byte first.
  function automatic logic [PIX_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        idx);
    return w[{idx, 3'b000} +: PIX_W];
  endfunction

endpackage

// File: rtl/vid_word_fifo.sv
// vid_word_fifo: synchronous show-ahead FIFO for framebuffer words.
//   clk, rst      : clock, asynchronous active-high reset (FIFO empties)
//   push, wr_data : write a word (ignored when full)
//   pop           : discard the head word (ignored when empty)
//   rd_data       : head word, read straight from the storage flops
//   empty, level  : occupancy, used by the reader for credit accounting
// A push into an empty FIFO is visible on rd_data the following cycle; a pop
// in that same cycle is ignored, so there is no flow-through path.
module vid_word_fifo
  import vid_scanout_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign push_ok = push & (level != LVL_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the pointers and level define
  // which entries are meaningful, and leaving the array out of reset keeps it
  // a plain register file / RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      level <= level + LVL_W'(1);
      else if (pop_ok && !push_ok) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/vid_scanout.sv
// vid_scanout: frame scan-out engine on the framebuffer video read port.
//   clk, rst        : clock, asynchronous active-high reset
//   frame_start     : one-cycle pulse, starts a frame scan when idle
//   busy            : scan in progress
//   v_addr_0, v_re_0: framebuffer word address / read strobe (registered)
//   v_data_1        : read data, valid the cycle after v_re_0
//   pix_data/valid/ready/first/last : palette index stream, LSB byte first
// Build option: VID_SCANOUT_THROTTLE_EN leaves at least one idle cycle after
// every read so the CPU port always gets a slot; pixel output is unchanged.
module vid_scanout
  import vid_scanout_pkg::*;
#(
  parameter int                N_WORDS    = DEFAULT_N_WORDS,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              busy,
  output logic [ADDR_W-1:0] v_addr_0,
  output logic              v_re_0,
  input  logic [WORD_W-1:0] v_data_1,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_first,
  output logic              pix_last
);

  localparam int                CNT_W     = $clog2(N_WORDS + 1);
  localparam int                LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(N_WORDS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;       // next address to issue
  logic [CNT_W-1:0]  cnt;        // index of the next word to issue
  logic              re_d;       // read data on v_data_1 this cycle
  logic [1:0]        idx;        // byte of the head word being presented
  logic [CNT_W-1:0]  out_cnt;    // index of the head word within the frame

  logic              throttle_ok;
  logic              credit_ok;
  logic              start;
  logic              fetch_issue;
  logic              hs;
  logic              pop;
  logic [LVL_W:0]    outstanding;
  logic [WORD_W-1:0] head;
  logic              fifo_empty;
  logic [LVL_W-1:0]  level;

`ifdef VID_SCANOUT_THROTTLE_EN
  assign throttle_ok = ~v_re_0;
`else
  assign throttle_ok = 1'b1;
`endif

  // Credits cover every word that will land in the FIFO: those stored, the
  // one on v_data_1 now, and the one requested by v_re_0. The capture path
  // has no back-pressure, so this is what keeps the FIFO from overflowing.
  // NOTE: every combinational output gets a default first so no path through
  // the block can hold a value and infer a latch.
  always_comb begin
    outstanding = '0;
    credit_ok   = 1'b0;
    outstanding = {1'b0, level} + {{LVL_W{1'b0}}, v_re_0} + {{LVL_W{1'b0}}, re_d};
    credit_ok   = outstanding < (LVL_W + 1)'(FIFO_DEPTH);
  end

  assign start       = (state == ST_IDLE) & frame_start;
  assign fetch_issue = (state == ST_FETCH) & credit_ok & throttle_ok;
  assign busy        = (state != ST_IDLE);

  // Read side: FSM, address generation and the registered RAM strobe.
  // The first read goes out together with the IDLE->FETCH transition so that
  // v_re_0 rises in the same cycle as busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      cnt      <= '0;
      v_addr_0 <= '0;
      v_re_0   <= 1'b0;
      re_d     <= 1'b0;
    end else begin
      re_d   <= v_re_0;
      v_re_0 <= start | fetch_issue;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            v_addr_0 <= BASE_ADDR;
            addr     <= BASE_ADDR + ADDR_W'(1);
            cnt      <= CNT_W'(1);
            state    <= (N_WORDS == 1) ? ST_DRAIN : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fetch_issue) begin
            v_addr_0 <= addr;
            addr     <= addr + ADDR_W'(1);
            cnt      <= cnt + CNT_W'(1);
            if (cnt == LAST_WORD) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (hs && pix_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  vid_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (re_d),
    .wr_data (v_data_1),
    .pop     (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Unpacker: the word being unpacked is the FIFO head, so a new word is
  // picked up as soon as one is stored and the pop on the byte-3 handshake
  // exposes the next word without a bubble.
  assign hs        = pix_valid & pix_ready;
  assign pop       = hs & (idx == 2'd3);
  assign pix_valid = ~fifo_empty;
  assign pix_data  = pix_valid ? word_byte(head, idx) : '0;
  assign pix_first = pix_valid & (idx == 2'd0) & (out_cnt == '0);
  assign pix_last  = pix_valid & (idx == 2'd3) & (out_cnt == LAST_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      out_cnt <= '0;
    end else if (hs) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) out_cnt <= pix_last ? '0 : out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vid_scanout.sv
// tb_vid_scanout: self-checking bench for vid_scanout.
// Main instance: 16-word frame whose base address wraps past the top of the
// 14-bit space; second instance: single-word frame.
// Expected pixels come from the frame definition: pixel i has value i,
// pix_first only on pixel 0, pix_last only on pixel 4*N-1.
module tb_vid_scanout;

  localparam int          N     = 16;
  localparam logic [13:0] BASE  = 14'd16380;
  localparam int          DEPTH = 4;
  localparam int          MAX_CYC = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        busy;
  logic [13:0] v_addr_0;
  logic        v_re_0;
  logic [31:0] v_data_1;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_first;
  logic        pix_last;

  logic        fs1;
  logic        busy1;
  logic [13:0] addr1;
  logic        re1;
  logic [31:0] d1;
  logic [7:0]  pd1;
  logic        pv1;
  logic        pf1;
  logic        pl1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vid_scanout #(.N_WORDS(N), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy),
    .v_addr_0(v_addr_0), .v_re_0(v_re_0), .v_data_1(v_data_1),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_first(pix_first), .pix_last(pix_last)
  );

  vid_scanout #(.N_WORDS(1), .BASE_ADDR(14'd100), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .frame_start(fs1), .busy(busy1),
    .v_addr_0(addr1), .v_re_0(re1), .v_data_1(d1),
    .pix_data(pd1), .pix_valid(pv1), .pix_ready(1'b1),
    .pix_first(pf1), .pix_last(pl1)
  );

  // Framebuffer: word k of the frame (k = addr - BASE, mod 2^14) holds
  // pixels 4k..4k+3, LSB byte first. One-cycle read latency.
  function automatic logic [31:0] ram_word(input logic [13:0] a);
    logic [13:0] k;
    int          p;
    k = a - BASE;
    p = 4 * int'(k);
    return {8'(p + 3), 8'(p + 2), 8'(p + 1), 8'(p)};
  endfunction

  always @(posedge clk) if (v_re_0) v_data_1 <= ram_word(v_addr_0);
  always @(posedge clk) if (re1) d1 <= (addr1 == 14'd100) ? 32'h0302_0100 : 32'hDEAD_BEEF;

  // Reference: {first, last, value} of pixel i in a frame of nw words.
  function automatic logic [9:0] exp_pix(input int i, input int nw);
    return {i == 0, i == 4 * nw - 1, 8'(i)};
  endfunction

  // Results of one frame run on the main instance.
  logic [9:0]  got_pix[$];
  int          lat_valid, stab_err, credit_err, consec_err;
  bit          timed_out;
  logic        busy_c1, re_c1, busy_end;
  logic [13:0] addr_c1;

  // Runs one frame: pulses frame_start, drives pix_ready at ready_pct %,
  // optionally re-pulses frame_start at cycle restart_at, and stops after
  // abort_at pixels if abort_at > 0. Inputs change at the falling edge and
  // outputs are sampled 1 time unit later.
  task automatic run_frame(input int ready_pct, input int restart_at, input int abort_at);
    int          issued, popped;
    bit          prev_stall, prev_re, done, finished;
    logic [9:0]  prev_pix;
    got_pix.delete();
    lat_valid = -1; stab_err = 0; credit_err = 0; consec_err = 0;
    issued = 0; popped = 0; prev_stall = 0; prev_re = 0; done = 0; finished = 0;
    prev_pix = '0; busy_end = 1'bx;
    for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
      @(negedge clk);
      frame_start = (cyc == 0) || (cyc == restart_at);
      pix_ready   = ($urandom_range(99) < ready_pct);
      #1;
      if (cyc == 1) begin busy_c1 = busy; re_c1 = v_re_0; addr_c1 = v_addr_0; end
      if (done) begin busy_end = busy; finished = 1; break; end
      if (v_re_0) begin
        issued++;
        if (prev_re) consec_err++;
      end
      prev_re = v_re_0;
      if (issued - popped > DEPTH) credit_err++;
      if (prev_stall && (!pix_valid || {pix_first, pix_last, pix_data} !== prev_pix)) stab_err++;
      if (pix_valid && lat_valid < 0) lat_valid = cyc;
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = {pix_first, pix_last, pix_data};
      if (pix_valid && pix_ready) begin
        got_pix.push_back({pix_first, pix_last, pix_data});
        if (got_pix.size() % 4 == 0) popped++;
        if (pix_last) done = 1;
        if (abort_at > 0 && got_pix.size() == abort_at) begin finished = 1; break; end
      end
    end
    frame_start = 1'b0;
    timed_out = !finished;
  endtask

  task automatic test_reset;
    int re_seen;
    rst = 1'b1; frame_start = 1'b0; pix_ready = 1'b0; fs1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (v_addr_0 !== 14'd0) begin errors++; $display("FAIL reset v_addr_0: got %h want 0", v_addr_0); end
    checks++; if (v_re_0 !== 1'b0)    begin errors++; $display("FAIL reset v_re_0: got %b want 0", v_re_0); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if ({pix_valid, pix_first, pix_last, pix_data} !== 11'd0)
      begin errors++; $display("FAIL reset pix_*: got v%b f%b l%b d%h want all 0", pix_valid, pix_first, pix_last, pix_data); end
    re_seen = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (v_re_0 || busy) re_seen++;
    end
    checks++; if (re_seen !== 0) begin errors++; $display("FAIL idle_no_reads: got %0d active cycles want 0", re_seen); end
  endtask

  task automatic test_full_rate;
    run_frame(100, -1, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL full_rate timeout: got %0d pixels want %0d", got_pix.size(), 4 * N); end
    checks++; if (got_pix.size() !== 4 * N) begin errors++; $display("FAIL full_rate count: got %0d want %0d", got_pix.size(), 4 * N); end
    for (int i = 0; i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix(i, N)) begin errors++; $display("FAIL full_rate pix[%0d]: got %h want %h", i, got_pix[i], exp_pix(i, N)); end
    end
    checks++; if (lat_valid !== 3) begin errors++; $display("FAIL full_rate latency: got %0d want 3", lat_valid); end
    checks++; if ({busy_c1, re_c1} !== 2'b11) begin errors++; $display("FAIL start_cycle busy/re: got %b%b want 11", busy_c1, re_c1); end
    checks++; if (addr_c1 !== BASE) begin errors++; $display("FAIL start_cycle addr: got %0d want %0d", addr_c1, BASE); end
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL full_rate busy_after_last: got %b want 0", busy_end); end
    checks++; if (credit_err !== 0) begin errors++; $display("FAIL full_rate outstanding: got %0d violations want 0", credit_err); end
`ifdef VID_SCANOUT_THROTTLE_EN
    checks++; if (consec_err !== 0) begin errors++; $display("FAIL throttle consecutive_reads: got %0d want 0", consec_err); end
`endif
  endtask

  task automatic test_backpressure;
    run_frame(30, -1, -1);
    checks++; if (got_pix.size() !== 4 * N || timed_out) begin errors++; $display("FAIL backpressure count: got %0d want %0d", got_pix.size(), 4 * N); end
    for (int i = 0; i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix(i, N)) begin errors++; $display("FAIL backpressure pix[%0d]: got %h want %h", i, got_pix[i], exp_pix(i, N)); end
    end
    checks++; if (credit_err !== 0) begin errors++; $display("FAIL backpressure outstanding: got %0d violations want 0", credit_err); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL backpressure stability: got %0d violations want 0", stab_err); end
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL backpressure busy_after_last: got %b want 0", busy_end); end
`ifdef VID_SCANOUT_THROTTLE_EN
    checks++; if (consec_err !== 0) begin errors++; $display("FAIL backpressure consecutive_reads: got %0d want 0", consec_err); end
`endif
  endtask

  task automatic test_ignored_restart;
    run_frame(70, 30, -1);
    checks++; if (got_pix.size() !== 4 * N || timed_out) begin errors++; $display("FAIL restart count: got %0d want %0d", got_pix.size(), 4 * N); end
    for (int i = 0; i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix(i, N)) begin errors++; $display("FAIL restart pix[%0d]: got %h want %h", i, got_pix[i], exp_pix(i, N)); end
    end
    run_frame(100, -1, -1);
    checks++; if (addr_c1 !== BASE) begin errors++; $display("FAIL second_frame addr: got %0d want %0d", addr_c1, BASE); end
    checks++; if (got_pix.size() !== 4 * N || timed_out) begin errors++; $display("FAIL second_frame count: got %0d want %0d", got_pix.size(), 4 * N); end
    for (int i = 0; i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix(i, N)) begin errors++; $display("FAIL second_frame pix[%0d]: got %h want %h", i, got_pix[i], exp_pix(i, N)); end
    end
  endtask

  task automatic test_reset_mid_scan;
    run_frame(80, -1, 20);
    checks++; if (got_pix.size() !== 20) begin errors++; $display("FAIL abort count: got %0d want 20", got_pix.size()); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, v_re_0, v_addr_0, pix_valid, pix_first, pix_last, pix_data} !== 27'd0)
      begin errors++; $display("FAIL mid_reset outputs: got busy%b re%b a%h v%b f%b l%b d%h want all 0",
                               busy, v_re_0, v_addr_0, pix_valid, pix_first, pix_last, pix_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame(100, -1, -1);
    checks++; if (got_pix.size() !== 4 * N || timed_out) begin errors++; $display("FAIL after_reset count: got %0d want %0d", got_pix.size(), 4 * N); end
    for (int i = 0; i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix(i, N)) begin errors++; $display("FAIL after_reset pix[%0d]: got %h want %h", i, got_pix[i], exp_pix(i, N)); end
    end
  endtask

  task automatic test_single_word;
    logic [9:0] got1[$];
    int         reads;
    logic       busy1_end;
    reads = 0; busy1_end = 1'bx;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      fs1 = (cyc == 0);
      #1;
      if (re1) reads++;
      if (pv1) got1.push_back({pf1, pl1, pd1});
      if (cyc == 19) busy1_end = busy1;
    end
    checks++; if (got1.size() !== 4) begin errors++; $display("FAIL single_word count: got %0d want 4", got1.size()); end
    for (int i = 0; i < got1.size(); i++) begin
      checks++;
      if (got1[i] !== exp_pix(i, 1)) begin errors++; $display("FAIL single_word pix[%0d]: got %h want %h", i, got1[i], exp_pix(i, 1)); end
    end
    checks++; if (reads !== 1) begin errors++; $display("FAIL single_word reads: got %0d want 1", reads); end
    checks++; if (busy1_end !== 1'b0) begin errors++; $display("FAIL single_word busy_end: got %b want 0", busy1_end); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_ignored_restart();
    test_reset_mid_scan();
    test_single_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
